// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side and memory-side buses of the data cache controller.
//   slave  : the cache controller (takes CPU requests, issues memory transfers)
//   master : the environment around it (CPU request source and data memory)
// CPU side   : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_ready out
// Memory side: mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in
interface dcache_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, blocking, write-through / no-write-allocate
// data cache controller with 4-word lines and burst refill on read miss.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   bus          : dcache_ctrl_if.slave (CPU request bus + memory bus)
//   hit_count    : 8-bit wrapping count of accesses that hit
//   access_count : 8-bit wrapping count of completed accesses
//
// Build option: define DCACHE_STATS_EN to build the two statistics
// counters; otherwise both outputs are tied to zero.
//
// state  | meaning
// IDLE   | waiting for cpu_req; tag lookup done on the sampling edge
// LOOKUP | hit known; read hit completes here, else route to REFILL/WRITE
// REFILL | 4-word burst read of the missing line
// WRITE  | single-word write-through to memory
// RESP   | cpu_ready pulse after REFILL or WRITE
module dcache_ctrl #(
   parameter int INDEX_W = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32
) (
   input  logic          clk,
   input  logic          rst,
   dcache_ctrl_if.slave  bus,
   output logic [7:0]    hit_count,
   output logic [7:0]    access_count
);
   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - 4;
   localparam int WA_W  = ADDR_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL,
      WRITE,
      RESP
   } state_t;

   state_t              state;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [DATA_W-1:0]   data_q [LINES*4];

   logic                req_we;
   logic [WA_W-1:0]     req_waddr;
   logic [DATA_W-1:0]   req_wdata;
   logic [1:0]          cnt;
   logic [1:0]          cnt_nx;
   logic                hit_r;

   logic                cpu_ready_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   // Incoming request fields, used for the lookup on the IDLE sampling edge
   logic [INDEX_W-1:0]  in_idx;
   logic [TAG_W-1:0]    in_tag;
   logic [1:0]          in_word;
   logic                in_hit;

   // Latched request fields
   logic [INDEX_W-1:0]  r_idx;
   logic [TAG_W-1:0]    r_tag;
   logic [1:0]          r_word;

   logic                unused_addr_lsb;

   assign in_idx  = bus.cpu_addr[INDEX_W+3:4];
   assign in_tag  = bus.cpu_addr[ADDR_W-1:INDEX_W+4];
   assign in_word = bus.cpu_addr[3:2];
   assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

   assign r_idx   = req_waddr[INDEX_W+1:2];
   assign r_tag   = req_waddr[WA_W-1:INDEX_W+2];
   assign r_word  = req_waddr[1:0];
   assign cnt_nx  = cnt + 2'd1;

   assign unused_addr_lsb = ^bus.cpu_addr[1:0];

   // The tag compare is done combinationally on the IDLE sampling edge so a
   // read hit can present registered data during the LOOKUP cycle itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         valid_q     <= '0;
         req_we      <= 1'b0;
         req_waddr   <= '0;
         req_wdata   <= '0;
         cnt         <= 2'd0;
         hit_r       <= 1'b0;
         cpu_ready_q <= 1'b0;
         cpu_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         cpu_ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_req) begin
                  req_we    <= bus.cpu_we;
                  req_waddr <= bus.cpu_addr[ADDR_W-1:2];
                  req_wdata <= bus.cpu_wdata;
                  hit_r     <= in_hit;
                  if (!bus.cpu_we && in_hit) begin
                     cpu_ready_q <= 1'b1;
                     cpu_rdata_q <= data_q[{in_idx, in_word}];
                  end
                  state <= LOOKUP;
               end
            end

            LOOKUP: begin
               if (!req_we) begin
                  if (hit_r) begin
                     state <= IDLE;
                  end else begin
                     cnt        <= 2'd0;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {r_tag, r_idx, 2'b00, 2'b00};
                     state      <= REFILL;
                  end
               end else begin
                  if (hit_r) begin
                     data_q[{r_idx, r_word}] <= req_wdata;
                  end
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {req_waddr, 2'b00};
                  mem_wdata_q <= req_wdata;
                  state       <= WRITE;
               end
            end

            REFILL: begin
               if (bus.mem_ack) begin
                  data_q[{r_idx, cnt}] <= bus.mem_rdata;
                  // capture the requested word as it streams past
                  if (cnt == r_word) begin
                     cpu_rdata_q <= bus.mem_rdata;
                  end
                  cnt <= cnt_nx;
                  if (cnt == 2'd3) begin
                     valid_q[r_idx] <= 1'b1;
                     tag_q[r_idx]   <= r_tag;
                     mem_req_q      <= 1'b0;
                     cpu_ready_q    <= 1'b1;
                     state          <= RESP;
                  end else begin
                     mem_addr_q <= {r_tag, r_idx, cnt_nx, 2'b00};
                  end
               end
            end

            WRITE: begin
               if (bus.mem_ack) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  cpu_ready_q <= 1'b1;
                  state       <= RESP;
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_ready = cpu_ready_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
   logic [7:0] hit_cnt_q;
   logic [7:0] acc_cnt_q;

   // hit_r stays valid through RESP, so write hits are credited on their
   // late cpu_ready pulse as well.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt_q <= 8'd0;
         acc_cnt_q <= 8'd0;
      end else if (cpu_ready_q) begin
         acc_cnt_q <= acc_cnt_q + 8'd1;
         if (hit_r) begin
            hit_cnt_q <= hit_cnt_q + 8'd1;
         end
      end
   end

   assign hit_count    = hit_cnt_q;
   assign access_count = acc_cnt_q;
`else
   assign hit_count    = 8'd0;
   assign access_count = 8'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench for dcache_ctrl.
module tb_dcache_ctrl;
`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] hit_count;
   logic [7:0] access_count;

   dcache_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   dcache_ctrl #(.INDEX_W(4), .DATA_W(32), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .hit_count    (hit_count),
      .access_count (access_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        chk_data;
      logic [31:0] data;
      int          lat;
      logic [7:0]  hit;
      logic [7:0]  acc;
   } cpu_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } mem_exp_t;

   cpu_exp_t    cpu_q [$];
   mem_exp_t    mem_q [$];
   logic [31:0] mem_store [logic [31:0]];

   int          checks = 0;
   int          errors = 0;
   int          mem_wait = 0;
   int          ack_total = 0;
   logic [7:0]  exp_hit = 8'd0;
   logic [7:0]  exp_acc = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return 32'hD000_0000 | a;
   endfunction

   // Memory model and memory-side checker
   initial begin
      int          wait_cnt;
      logic [31:0] held_addr;
      mem_exp_t    m;
      wait_cnt      = 0;
      held_addr     = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
         end else if (bus.mem_req) begin
            if (wait_cnt > 0) check("mem_addr_stable", bus.mem_addr, held_addr);
            held_addr = bus.mem_addr;
            if (wait_cnt < mem_wait) begin
               wait_cnt++;
               bus.mem_ack = 1'b0;
            end else begin
               wait_cnt    = 0;
               bus.mem_ack = 1'b1;
               ack_total++;
               if (mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_unexpected: got addr 0x%08h we %0b, required no transfer",
                           bus.mem_addr, bus.mem_we);
               end else begin
                  m = mem_q.pop_front();
                  check("mem_addr", bus.mem_addr, m.addr);
                  check("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
                  if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
               end
               if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
               else bus.mem_rdata = mem_read(bus.mem_addr);
            end
         end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
         end
      end
   end

   // CPU-side monitor: pops the scoreboard on every cpu_ready pulse
   initial begin
      bit         in_flight;
      bit         cnt_pending;
      int         edges;
      cpu_exp_t   e;
      logic [7:0] p_hit;
      logic [7:0] p_acc;
      in_flight   = 1'b0;
      cnt_pending = 1'b0;
      edges       = 0;
      p_hit       = '0;
      p_acc       = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_flight   = 1'b0;
            cnt_pending = 1'b0;
         end else begin
            if (cnt_pending) begin
               check("hit_count", {24'd0, hit_count}, {24'd0, p_hit});
               check("access_count", {24'd0, access_count}, {24'd0, p_acc});
               cnt_pending = 1'b0;
            end
            if (in_flight) begin
               edges++;
               if (bus.cpu_ready) begin
                  in_flight = 1'b0;
                  if (cpu_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL cpu_unexpected: got cpu_ready with no access expected");
                  end else begin
                     e = cpu_q.pop_front();
                     if (e.chk_data) check("cpu_rdata", bus.cpu_rdata, e.data);
                     check("latency", edges, e.lat);
                     p_hit       = e.hit;
                     p_acc       = e.acc;
                     cnt_pending = 1'b1;
                  end
               end
            end else if (bus.cpu_ready) begin
               checks++;
               errors++;
               $display("FAIL cpu_ready_idle: got cpu_ready=1, required 0");
            end else if (bus.cpu_req) begin
               in_flight = 1'b1;
               edges     = 0;
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cpu_ready && n < 200);
      if (!bus.cpu_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got no cpu_ready in %0d cycles, required one", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic hit, input logic [31:0] rdata, input int lat);
      cpu_exp_t    e;
      mem_exp_t    m;
      logic [31:0] base;
      base = {addr[31:4], 4'h0};
      if (we) begin
         m.addr = {addr[31:2], 2'b00};
         m.we = 1'b1;
         m.wdata = wdata;
         mem_q.push_back(m);
      end else if (!hit) begin
         for (int i = 0; i < 4; i++) begin
            m.addr = base + 32'(i * 4);
            m.we = 1'b0;
            m.wdata = '0;
            mem_q.push_back(m);
         end
      end
      exp_acc = exp_acc + 8'd1;
      if (hit) exp_hit = exp_hit + 8'd1;
      e.chk_data = !we;
      e.data     = rdata;
      e.lat      = lat;
      e.hit      = STATS ? exp_hit : 8'd0;
      e.acc      = STATS ? exp_acc : 8'd0;
      cpu_q.push_back(e);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      wait_ready();
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      mem_exp_t m;
      int       start;
      int       n;
      rst           = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      mem_store[32'h100] = 32'hA0;
      mem_store[32'h104] = 32'hA1;
      mem_store[32'h108] = 32'hA2;
      mem_store[32'h10C] = 32'hA3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_hit_count", {24'd0, hit_count}, 32'd0);
      check("rst_access_count", {24'd0, access_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // cold miss, hit, write hit, read-back
      do_access(1'b0, 32'h100, 32'h0, 1'b0, 32'hA0, 6);
      do_access(1'b0, 32'h108, 32'h0, 1'b1, 32'hA2, 1);
      do_access(1'b1, 32'h104, 32'h55, 1'b1, 32'h0, 3);
      do_access(1'b0, 32'h104, 32'h0, 1'b1, 32'h55, 1);

      // write miss with wait states, then read refills (no allocate)
      mem_wait = 2;
      do_access(1'b1, 32'h200, 32'h77, 1'b0, 32'h0, 5);
      mem_wait = 1;
      do_access(1'b0, 32'h200, 32'h0, 1'b0, 32'h77, 10);
      mem_wait = 0;

      // conflicts on index 0
      do_access(1'b0, 32'h100, 32'h0, 1'b0, 32'hA0, 6);
      do_access(1'b0, 32'h1100, 32'h0, 1'b0, 32'hD000_1100, 6);
      do_access(1'b0, 32'h100, 32'h0, 1'b0, 32'hA0, 6);
      do_access(1'b0, 32'h104, 32'h0, 1'b1, 32'h55, 1);

      // reset after the 2nd refill ack
      m.we = 1'b0;
      m.wdata = '0;
      m.addr = 32'h300;
      mem_q.push_back(m);
      m.addr = 32'h304;
      mem_q.push_back(m);
      start = ack_total;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h30C;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (ack_total < start + 2 && n < 100);
      check("mid_reset_acks", ack_total - start, 2);
      #1;
      rst         = 1'b0;
      bus.cpu_req = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("mid_rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
      check("mid_rst_hit_count", {24'd0, hit_count}, 32'd0);
      check("mid_rst_access_count", {24'd0, access_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_hit = 8'd0;
      exp_acc = 8'd0;

      do_access(1'b0, 32'h30C, 32'h0, 1'b0, 32'hD000_030C, 6);
      do_access(1'b0, 32'h307, 32'h0, 1'b1, 32'hD000_0304, 1);

      // 256 hits: hit_count passes 255 -> 0
      for (int i = 0; i < 256; i++) begin
         do_access(1'b0, 32'h308, 32'h0, 1'b1, 32'hD000_0308, 1);
      end

      repeat (4) @(negedge clk);
      check("cpu_q_empty", cpu_q.size(), 0);
      check("mem_q_empty", mem_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

- Direct-mapped, blocking, write-through / no-write-allocate data cache controller.
- Sits between the pipeline's memory stage and data memory inside `top`.
- Produces the `hit_count` statistic exported by `top`, plus an access count.
- Lines are 4 words; a read miss refills the whole line as a burst from memory.

## Interface

Parameters:
- `INDEX_W`, 4: index bits; the cache has 2^INDEX_W lines.
- `DATA_W`, 32: word width.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `cpu_req`, in, 1: request valid; the CPU holds it and all request fields stable until `cpu_ready`.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_addr`, in, ADDR_W: byte address; bits [1:0] are ignored.
- `cpu_wdata`, in, DATA_W: write data.
- `cpu_rdata`, out, DATA_W: read data; valid only while `cpu_ready` is 1.
- `cpu_ready`, out, 1: one-cycle completion pulse.
- `mem_req`, out, 1: memory request; held until `mem_ack`.
- `mem_we`, out, 1: memory write.
- `mem_addr`, out, ADDR_W: word-aligned memory address.
- `mem_wdata`, out, DATA_W: memory write data.
- `mem_rdata`, in, DATA_W: memory read data; valid with `mem_ack`.
- `mem_ack`, in, 1: completes one word transfer.
- `hit_count`, out, 8: cache hits, wrapping.
- `access_count`, out, 8: completed accesses, wrapping.

## Operation

Address split:
- Word select = [3:2].
- Index = [INDEX_W+3:4].
- Tag = [ADDR_W-1:INDEX_W+4].

Storage: per line, one valid bit, one tag and 4 data words.

States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- **IDLE**
  - If `cpu_req` = 1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to LOOKUP.
  - Otherwise stay in IDLE.
- **LOOKUP**
  - Hit = the indexed line is valid and its tag matches.
  - Read hit: assert `cpu_ready` with the selected word, then go to IDLE.
  - Read miss: go to REFILL with word counter = 0.
  - Write, hit or miss: on a hit, update the cached word in this cycle; then go to WRITE.
- **REFILL**
  - `mem_req` = 1, `mem_we` = 0.
  - `mem_addr` = {tag, index, counter, 2'b00}.
  - Each `mem_ack` stores `mem_rdata` into word[counter] and increments the counter.
  - On the 4th ack, set the line's valid bit and tag, then go to RESP.
- **RESP**
  - Assert `cpu_ready` with `cpu_rdata` = word[addr[3:2]] of the new line.
  - Go to IDLE.
- **WRITE**
  - `mem_req` = 1, `mem_we` = 1, `mem_addr` = latched word address, `mem_wdata` = latched data.
  - On `mem_ack`, assert `cpu_ready` in the next cycle via RESP.
  - On a write miss, no line is allocated and no valid bit or tag changes.

Counters (when compiled in):
- `access_count` increments by 1 on every `cpu_ready` pulse.
- `hit_count` increments on the `cpu_ready` of each access whose LOOKUP was a hit; this includes write hits, whose pulse comes after WRITE.
- Both are 8-bit and wrap 255 → 0 with no saturation or flag.

## Timing

Reset values (when `rst` = 0 at a rising edge):
- State = IDLE; all valid bits = 0; counters = 0.
- `cpu_ready`, `mem_req` and `mem_we` = 0.
- `mem_addr`, `mem_wdata` and `cpu_rdata` = 0.

Latency, counted as rising edges from the edge at which IDLE samples `cpu_req`:
- Read hit: `cpu_ready` is high in the cycle after that edge (1 cycle).
- Read miss: 2 + N cycles, where N is the number of cycles up to and including the 4th ack. With zero-wait memory (`mem_ack` in every REFILL cycle), `cpu_ready` arrives at cycle 6.
- Write: 3 cycles with zero-wait memory.

Handshake and boundary rules:
- `mem_req` stays asserted with a stable address and data until the `mem_ack` cycle.
- Back-to-back requests: the `cpu_ready` cycle never samples a new request. The next request is sampled at the earliest in the cycle after `cpu_ready`, giving 1 bubble minimum.
- `mem_ack` outside REFILL or WRITE is ignored.
- `cpu_req` dropping before `cpu_ready` is a protocol violation; the behaviour is unspecified.
- Reset in the middle of REFILL or WRITE:
  - abandons the transfer and drops `mem_req` at that edge;
  - leaves the partially filled line invalid;
  - makes the next access a miss.
- A hit and a counter wrap in the same cycle are handled normally, so `hit_count` can read lower than before the wrap.

## Configuration

- `DCACHE_STATS_EN` defined: `hit_count` and `access_count` are implemented as described above.
- `DCACHE_STATS_EN` not defined: no counter registers are built, and both outputs are tied to 8'd0. All cache behaviour and timing are unchanged.

## Test plan

1. Reset, then read 0x100 with memory returning 0xA0..0xA3 for words 0..3 at zero wait → `mem_addr` steps 0x100, 0x104, 0x108, 0x10C; `cpu_rdata` = 0xA0; `hit_count` = 0, `access_count` = 1.
2. Then read 0x108 → `cpu_ready` 1 cycle after sampling, `cpu_rdata` = 0xA2, no `mem_req`, `hit_count` = 1.
3. Write 0x104 = 0x55 (hit) → one `mem_req` with `mem_we` = 1, `mem_addr` = 0x104, `mem_wdata` = 0x55; a read of 0x104 then returns 0x55 with no memory access.
4. Write-miss 0x200 followed by a read of 0x200 → the read refills (miss, `mem_addr` = 0x200), confirming no allocate; `hit_count` unchanged.
5. Conflict test: read 0x100, then 0x1100 (same index 0, different tag), then 0x100 → three refills, all misses.
6. Assert reset after the 2nd refill ack, then read the same address → full 4-word refill again. Separately, 256 read hits wrap `hit_count` from 255 to 0. With `DCACHE_STATS_EN` undefined, both counters stay 0 throughout.
